// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int DCACHE_DATA_WIDTH = 32;

  localparam logic [DCACHE_DATA_WIDTH-1:0] MMIO_TRIGGER_ADDR = 32'h000000FC;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    FLUSH
  } dcache_state_t;

  // The tag is held full-width (address >> index bits) so LINES can change without retyping.
  typedef struct packed {
    logic                         valid;
    logic                         dirty;
    logic [DCACHE_DATA_WIDTH-1:0] tag;
    logic [DCACHE_DATA_WIDTH-1:0] data;
  } dcache_line_t;

endpackage

// File: rtl/dcache_array.sv
// Line storage: combinational read, synchronous write, valid/dirty cleared on reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter  int LINES      = 16,
  localparam int INDEX_BITS = $clog2(LINES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  output dcache_line_t          rd_line,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  dcache_line_t          wr_line
);

  logic [LINES-1:0]             valid_q;
  logic [LINES-1:0]             dirty_q;
  logic [DCACHE_DATA_WIDTH-1:0] tag_mem  [LINES];
  logic [DCACHE_DATA_WIDTH-1:0] data_mem [LINES];

  always_comb begin
    rd_line.valid = valid_q[rd_index];
    rd_line.dirty = dirty_q[rd_index];
    rd_line.tag   = tag_mem[rd_index];
    rd_line.data  = data_mem[rd_index];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= wr_line.valid;
      dirty_q[wr_index] <= wr_line.dirty;
    end
  end

  // NOTE: tag/data arrays have no reset; invalid lines are never read as hits, and a reset-free array maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_line.tag;
      data_mem[wr_index] <= wr_line.data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate cache controller with MMIO bypass and whole-cache flush.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = DCACHE_DATA_WIDTH,
  parameter int LINES      = 16,
  parameter int MEM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  busy,
  output logic                  mem_fetch,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_writeback,
  output logic [DATA_WIDTH-1:0] mem_wb_addr,
  output logic [DATA_WIDTH-1:0] mem_wb_data
);

  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = DATA_WIDTH - INDEX_BITS;
  localparam int WAIT_BITS  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  dcache_state_t         state, next_state;
  logic [WAIT_BITS-1:0]  wait_cnt;
  logic [INDEX_BITS:0]   flush_cnt;
  logic                  rst_hold;

  logic [INDEX_BITS-1:0] index;
  logic [DATA_WIDTH-1:0] req_tag;
  dcache_line_t          line, wr_line;
  logic                  wr_en, is_mmio, hit, wait_last, flush_end;

  assign req_tag   = req_addr >> INDEX_BITS;
  assign index     = (state == FLUSH) ? flush_cnt[INDEX_BITS-1:0] : req_addr[INDEX_BITS-1:0];
  assign is_mmio   = req_valid && (req_addr == MMIO_TRIGGER_ADDR);
  assign hit       = req_valid && !is_mmio && line.valid && (line.tag == req_tag);
  assign wait_last = (wait_cnt == WAIT_BITS'(MEM_LAT - 1));
  assign flush_end = (flush_cnt == (INDEX_BITS+1)'(LINES));

  dcache_array #(.LINES(LINES)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (index),
    .rd_line  (line),
    .wr_en    (wr_en),
    .wr_index (index),
    .wr_line  (wr_line)
  );

  // rst_hold marks the cycle after reset was sampled; outputs and actions are suppressed there.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COMPARE;
      wait_cnt  <= '0;
      flush_cnt <= '0;
      rst_hold  <= 1'b1;
    end else begin
      state     <= next_state;
      rst_hold  <= 1'b0;
      wait_cnt  <= (state == ALLOCATE && !wait_last) ? wait_cnt + WAIT_BITS'(1) : '0;
      flush_cnt <= (state == FLUSH && !flush_end) ? flush_cnt + (INDEX_BITS+1)'(1) : '0;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    if (!rst_hold) begin
      case (state)
        COMPARE: begin
          if (req_valid && !is_mmio && !hit)
            next_state = (line.valid && line.dirty) ? WRITEBACK : ALLOCATE;
          else if (!req_valid && flush_req)
            next_state = FLUSH;
        end
        WRITEBACK: next_state = ALLOCATE;
        ALLOCATE:  if (wait_last) next_state = COMPARE;
        FLUSH:     if (flush_end) next_state = COMPARE;
        default:   next_state = COMPARE;
      endcase
    end
  end

  always_comb begin
    req_ready     = 1'b0;
    rdata         = '0;
    flush_done    = 1'b0;
    busy          = 1'b0;
    mem_fetch     = 1'b0;
    mem_addr      = '0;
    mem_writeback = 1'b0;
    mem_wb_addr   = '0;
    mem_wb_data   = '0;
    wr_en         = 1'b0;
    wr_line       = line;
    if (!rst_hold) begin
      busy = (state != COMPARE);
      case (state)
        COMPARE: begin
          if (is_mmio) begin
            mem_addr  = MMIO_TRIGGER_ADDR;
            rdata     = mem_rdata;
            req_ready = 1'b1;
          end else if (hit) begin
            req_ready = 1'b1;
            rdata     = line.data;
            if (req_we) begin
              wr_en         = 1'b1;
              wr_line.data  = req_wdata;
              wr_line.dirty = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          mem_writeback = 1'b1;
          mem_wb_addr   = {line.tag[TAG_BITS-1:0], index};
          mem_wb_data   = line.data;
          wr_en         = 1'b1;
          wr_line.dirty = 1'b0;
        end
        ALLOCATE: begin
          mem_fetch = 1'b1;
          mem_addr  = req_addr;
          if (wait_last) begin
            wr_en         = 1'b1;
            wr_line.valid = 1'b1;
            wr_line.dirty = 1'b0;
            wr_line.tag   = req_tag;
            wr_line.data  = mem_rdata;
          end
        end
        FLUSH: begin
          if (flush_end) begin
            flush_done = 1'b1;
          end else if (line.valid && line.dirty) begin
            mem_writeback = 1'b1;
            mem_wb_addr   = {line.tag[TAG_BITS-1:0], index};
            mem_wb_data   = line.data;
            wr_en         = 1'b1;
            wr_line.dirty = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: misses, eviction, MMIO, flush, overlap and reset abort.
module tb_dcache_controller;

  localparam int DW      = 32;
  localparam int LINES   = 16;
  localparam int MEM_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, flush_req = 1'b0;
  logic [DW-1:0] req_addr = '0, req_wdata = '0;
  logic          req_ready, flush_done, busy, mem_fetch, mem_writeback;
  logic [DW-1:0] rdata, mem_addr, mem_rdata, mem_wb_addr, mem_wb_data;

  always #5 clk = ~clk;

  dcache_controller #(.DATA_WIDTH(DW), .LINES(LINES), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rdata(rdata),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
    .mem_fetch(mem_fetch), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_writeback(mem_writeback), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data)
  );

  // Small memory model: word index is {addr[19:16], addr[3:0]}; bench addresses stay unique under it.
  logic [31:0] mem [0:255];
  function automatic logic [7:0] midx(input logic [31:0] a);
    return 8'(((a >> 12) & 32'h000000F0) | (a & 32'h0000000F));
  endfunction
  assign mem_rdata = mem[midx(mem_addr)];
  always @(posedge clk) if (mem_writeback) mem[midx(mem_wb_addr)] <= mem_wb_data;

  int total = 0, bad = 0, overlap = 0;
  always @(negedge clk) if (mem_fetch && mem_writeback) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  int          acc_cyc, acc_fetch, acc_wb;
  logic [31:0] acc_rdata, acc_fetch_addr, acc_wb_addr, acc_wb_data;

  // Holds one request until req_ready (bounded); acc_cyc stays 0 on timeout.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    acc_cyc = 0; acc_fetch = 0; acc_wb = 0;
    acc_rdata = '0; acc_fetch_addr = '0; acc_wb_addr = '0; acc_wb_data = '0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_fetch) begin acc_fetch++; acc_fetch_addr = mem_addr; end
      if (mem_writeback) begin acc_wb++; acc_wb_addr = mem_wb_addr; acc_wb_data = mem_wb_data; end
      if (req_ready) begin acc_cyc = c; acc_rdata = rdata; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  int          fl_done, fl_wb;
  int          fl_cyc  [4];
  logic [31:0] fl_addr [4];

  // Cycle 0 is the COMPARE cycle seeing flush_req; FLUSH cycles count from 1.
  task automatic run_flush();
    fl_done = 0; fl_wb = 0;
    for (int i = 0; i < 4; i++) begin fl_cyc[i] = 0; fl_addr[i] = '0; end
    flush_req = 1'b1;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) flush_req = 1'b0;
      if (mem_writeback) begin
        if (fl_wb < 4) begin fl_cyc[fl_wb] = n; fl_addr[fl_wb] = mem_wb_addr; end
        fl_wb++;
      end
      if (flush_done) begin fl_done = n; break; end
    end
    flush_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    mem[midx(32'h0001_0000)] = 32'h1111_1111;
    mem[midx(32'h0000_00FC)] = 32'h0000_0001;
    mem[midx(32'h0002_0001)] = 32'h2222_2222;

    // Reset with an MMIO load pending: every output must still be 0.
    req_valid = 1'b1; req_addr = 32'h0000_00FC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 32'({req_ready, flush_done, busy, mem_fetch, mem_writeback}), 32'h0);
    check("rst_data", rdata | mem_addr | mem_wb_addr | mem_wb_data, 32'h0);
    req_valid = 1'b0; req_addr = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold load miss then repeat hit.
    access(1'b0, 32'h0001_0000, '0);
    check("cold_cyc", acc_cyc, 4);
    check("cold_fetch_n", acc_fetch, 2);
    check("cold_fetch_addr", acc_fetch_addr, 32'h0001_0000);
    check("cold_rdata", acc_rdata, 32'h1111_1111);
    access(1'b0, 32'h0001_0000, '0);
    check("hit_cyc", acc_cyc, 1);
    check("hit_rdata", acc_rdata, 32'h1111_1111);

    // Dirty eviction at index 1.
    access(1'b1, 32'h0001_0001, 32'hDEAD_BEEF);
    check("st_miss_cyc", acc_cyc, 4);
    access(1'b0, 32'h0002_0001, '0);
    check("evict_cyc", acc_cyc, 5);
    check("evict_wb_n", acc_wb, 1);
    check("evict_wb_addr", acc_wb_addr, 32'h0001_0001);
    check("evict_wb_data", acc_wb_data, 32'hDEAD_BEEF);
    check("evict_fetch_n", acc_fetch, 2);
    check("evict_fetch_addr", acc_fetch_addr, 32'h0002_0001);
    check("evict_rdata", acc_rdata, 32'h2222_2222);
    access(1'b0, 32'h0001_0001, '0);
    check("reload_cyc", acc_cyc, 4);
    check("reload_rdata", acc_rdata, 32'hDEAD_BEEF);

    // MMIO bypass leaves the line at index 0xC alone.
    access(1'b0, 32'h0001_000C, '0);
    check("idx_c_miss_cyc", acc_cyc, 4);
    access(1'b0, 32'h0000_00FC, '0);
    check("mmio_cyc", acc_cyc, 1);
    check("mmio_rdata", acc_rdata, 32'h1);
    check("mmio_fetch_n", acc_fetch, 0);
    access(1'b1, 32'h0000_00FC, 32'h5555_5555);
    check("mmio_st_cyc", acc_cyc, 1);
    check("mmio_st_wb_n", acc_wb, 0);
    access(1'b0, 32'h0001_000C, '0);
    check("idx_c_hit_cyc", acc_cyc, 1);
    check("idx_c_hit_rdata", acc_rdata, 32'hA000_001C);
    access(1'b0, 32'h0000_00FC, '0);
    check("mmio_after_st", acc_rdata, 32'h1);

    // Flush with dirty lines at 2, 5, 9.
    access(1'b1, 32'h0001_0002, 32'h0000_0222);
    access(1'b1, 32'h0001_0005, 32'h0000_0555);
    access(1'b1, 32'h0001_0009, 32'h0000_0999);
    run_flush();
    check("flush_wb_n", fl_wb, 3);
    check("flush_wb0_cyc", fl_cyc[0], 3);
    check("flush_wb1_cyc", fl_cyc[1], 6);
    check("flush_wb2_cyc", fl_cyc[2], 10);
    check("flush_wb0_addr", fl_addr[0], 32'h0001_0002);
    check("flush_wb1_addr", fl_addr[1], 32'h0001_0005);
    check("flush_wb2_addr", fl_addr[2], 32'h0001_0009);
    check("flush_done_cyc", fl_done, 17);
    check("flush_mem5", mem[midx(32'h0001_0005)], 32'h0000_0555);
    run_flush();
    check("reflush_wb_n", fl_wb, 0);
    check("reflush_done_cyc", fl_done, 17);
    access(1'b0, 32'h0001_0005, '0);
    check("post_flush_hit_cyc", acc_cyc, 1);
    check("post_flush_rdata", acc_rdata, 32'h0000_0555);

    // flush_req together with a load miss: load first, FLUSH after req_valid drops.
    flush_req = 1'b1;
    access(1'b0, 32'h0004_0003, '0);
    check("simul_ld_cyc", acc_cyc, 4);
    check("simul_ld_rdata", acc_rdata, 32'hA000_0043);
    @(negedge clk);
    check("simul_idle_busy", 32'(busy), 32'h0);
    fl_done = 0; fl_wb = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("simul_flush_busy", 32'(busy), 32'h1);
        flush_req = 1'b0;
      end
      if (mem_writeback) fl_wb++;
      if (flush_done) begin fl_done = n; break; end
    end
    flush_req = 1'b0;
    check("simul_done_cyc", fl_done, 17);
    check("simul_wb_n", fl_wb, 0);
    @(posedge clk); #1;

    // Reset during ALLOCATE cycle 1 aborts the fill.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0003_0003;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_alloc_fetch", 32'(mem_fetch), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_ctrl", 32'({req_ready, flush_done, busy, mem_fetch, mem_writeback}), 32'h0);
    check("abort_data", rdata | mem_addr | mem_wb_addr | mem_wb_data, 32'h0);
    rst_n = 1'b1;
    req_valid = 1'b0; req_addr = '0;
    @(posedge clk); #1;
    access(1'b0, 32'h0003_0003, '0);
    check("abort_remiss_cyc", acc_cyc, 4);
    check("abort_remiss_wb", acc_wb, 0);
    check("abort_remiss_rdata", acc_rdata, 32'hA000_0033);
    access(1'b0, 32'h0001_000C, '0);
    check("rst_cleared_valid", acc_cyc, 4);

    check("fetch_wb_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
